// File: rtl/life_pkg.sv
// life_pkg: shared state encoding and default sizing for the generation sequencer.
package life_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_WAIT     = 3'd2,
        S_RUN      = 3'd3,
        S_DONEWAIT = 3'd4,
        S_STORE    = 3'd5
    } state_t;

    localparam int DEF_ROWS  = 4;
    localparam int DEF_DELAY = 99999999;
    localparam int DEF_GEN_W = 16;
    localparam int TIMER_W   = 32;

endpackage

// File: rtl/life_gen_sequencer_if.sv
// life_gen_sequencer_if: host command, array and memory strobes of the sequencer.
// master = host/array side, slave = sequencer.
interface life_gen_sequencer_if #(
    parameter int ROWS  = 4,
    parameter int GEN_W = 16
);
    localparam int ROW_W = $clog2(ROWS);

    logic             cmd_run;
    logic             cmd_step;
    logic             cmd_load;
    logic             array_done;
    logic             array_changed;
    logic [ROW_W-1:0] row_addr;
    logic             array_write;
    logic             array_run;
    logic             mem_write;
    logic             busy;
    logic [GEN_W-1:0] gen_count;
    logic [2:0]       state_o;

    modport master (
        output cmd_run, cmd_step, cmd_load, array_done, array_changed,
        input  row_addr, array_write, array_run, mem_write, busy, gen_count, state_o
    );

    modport slave (
        input  cmd_run, cmd_step, cmd_load, array_done, array_changed,
        output row_addr, array_write, array_run, mem_write, busy, gen_count, state_o
    );

endinterface

// File: rtl/life_period_timer.sv
// life_period_timer: 32-bit idle-period counter; o_expire flags count == DELAY.
module life_period_timer
    import life_pkg::*;
#(
    parameter int DELAY = DEF_DELAY
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);
    logic [TIMER_W-1:0] r_count;

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = (r_count == TIMER_W'(DELAY));

endmodule

// File: rtl/life_gen_sequencer.sv
// life_gen_sequencer: drives load, timed compute and store-back phases of the cell array.
// Optional build macro LIFE_AUTOSTOP_EN stops run mode once a generation changes nothing.
module life_gen_sequencer
    import life_pkg::*;
#(
    parameter int ROWS  = DEF_ROWS,
    parameter int ROW_W = $clog2(ROWS),
    parameter int DELAY = DEF_DELAY,
    parameter int GEN_W = DEF_GEN_W
) (
    input  logic clk,
    input  logic reset,
    life_gen_sequencer_if.slave bus
);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    state_t           r_state;
    logic [ROW_W-1:0] r_row;
    logic [GEN_W-1:0] r_gen;
    logic             w_expire;
    logic             w_stopped;
    logic             w_row_last;
    logic             w_timer_clear;
    logic             w_timer_en;

    assign w_row_last    = (r_row == ROW_LAST);
    assign w_timer_en    = (r_state == S_WAIT);
    assign w_timer_clear = (r_state != S_WAIT) || w_expire;

    life_period_timer #(.DELAY(DELAY)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_timer_clear),
        .i_enable (w_timer_en),
        .o_expire (w_expire)
    );

`ifdef LIFE_AUTOSTOP_EN
    logic r_stopped;

    // A generation that changed no cell pins the sequencer in IDLE until the host steps or reloads.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stopped <= 1'b0;
        end else if (r_state == S_DONEWAIT && bus.array_done && !bus.array_changed) begin
            r_stopped <= 1'b1;
        end else if (r_state == S_IDLE && (bus.cmd_step || bus.cmd_load)) begin
            r_stopped <= 1'b0;
        end
    end

    assign w_stopped = r_stopped;
`else
    logic w_unused_changed;

    assign w_unused_changed = bus.array_changed;
    assign w_stopped        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_row   <= '0;
            r_gen   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_load) begin
                        r_state <= S_LOAD;
                        r_row   <= '0;
                    end else if (bus.cmd_step) begin
                        r_state <= S_RUN;
                    end else if (bus.cmd_run && !w_stopped) begin
                        r_state <= S_WAIT;
                    end
                end
                S_LOAD: begin
                    if (w_row_last) begin
                        r_state <= S_IDLE;
                        r_row   <= '0;
                    end else begin
                        r_row <= r_row + 1'b1;
                    end
                end
                // Dropping cmd_run wins over both an early step and timer expiry.
                S_WAIT: begin
                    if (!bus.cmd_run) begin
                        r_state <= S_IDLE;
                    end else if (bus.cmd_step || w_expire) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: r_state <= S_DONEWAIT;
                S_DONEWAIT: begin
                    if (bus.array_done) begin
                        r_state <= S_STORE;
                        r_row   <= '0;
                    end
                end
                S_STORE: begin
                    if (w_row_last) begin
                        r_row   <= '0;
                        r_gen   <= r_gen + 1'b1;
                        r_state <= (bus.cmd_run && !w_stopped) ? S_WAIT : S_IDLE;
                    end else begin
                        r_row <= r_row + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.row_addr    = r_row;
    assign bus.array_write = (r_state == S_LOAD);
    assign bus.array_run   = (r_state == S_RUN);
    assign bus.mem_write   = (r_state == S_STORE);
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.gen_count   = r_gen;
    assign bus.state_o     = r_state;

endmodule

// File: tb/tb_life_gen_sequencer.sv
// tb_life_gen_sequencer: scripted-transaction reference with randomized latencies, noise and commands.
// Build with +define+LIFE_AUTOSTOP_EN to exercise the auto-stop variant.
module tb_life_gen_sequencer;
    localparam int ROWS    = 4;
    localparam int DELAY   = 3;
    localparam int GEN_W   = 2;
    localparam int GEN_MOD = 1 << GEN_W;

    localparam int ST_IDLE = 0, ST_LOAD = 1, ST_WAIT = 2, ST_RUN = 3, ST_DW = 4, ST_STORE = 5;

`ifdef LIFE_AUTOSTOP_EN
    localparam bit AUTOSTOP = 1'b1;
`else
    localparam bit AUTOSTOP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    life_gen_sequencer_if #(.ROWS(ROWS), .GEN_W(GEN_W)) bus ();

    life_gen_sequencer #(.ROWS(ROWS), .DELAY(DELAY), .GEN_W(GEN_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_gen  = 0;
    int cyc_no   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, expv);
        end
    endtask

    function automatic bit rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Packed view: [26:24] state, [19] array_write, [18] array_run, [17] mem_write, [16] busy,
    // [15:8] row_addr, [7:0] gen_count.
    task automatic cyc(input string tag, input int st, input int row);
        logic [31:0] obs;
        logic [31:0] expv;
        @(negedge clk);
        cyc_no++;
        obs  = {5'b0, bus.state_o, 4'b0, bus.array_write, bus.array_run, bus.mem_write,
                bus.busy, 8'(bus.row_addr), 8'(bus.gen_count)};
        expv = (st << 24) | (int'(st == ST_LOAD) << 19) | (int'(st == ST_RUN) << 18)
             | (int'(st == ST_STORE) << 17) | (int'(st != ST_IDLE) << 16) | (row << 8) | exp_gen;
        check(tag, obs, expv);
    endtask

    task automatic clear_cmds();
        bus.cmd_run    = 1'b0;
        bus.cmd_step   = 1'b0;
        bus.cmd_load   = 1'b0;
        bus.array_done = 1'b0;
    endtask

    // Called at an IDLE negedge; cmd_load must win over any simultaneous step/run.
    task automatic do_load();
        bus.cmd_load = 1'b1;
        bus.cmd_step = rbit();
        bus.cmd_run  = rbit();
        for (int r = 0; r < ROWS; r++) begin
            cyc("load_row", ST_LOAD, r);
            bus.cmd_load = rbit();
            bus.cmd_step = rbit();
            bus.cmd_run  = rbit();
            if (r == ROWS - 1) clear_cmds();
        end
        cyc("load_idle", ST_IDLE, 0);
    endtask

    // Called right after the RUN cycle was checked; done arrives after lat DONEWAIT cycles.
    // abort_row >= 0 asserts reset on that STORE row and returns early.
    task automatic gen_body(input int lat, input bit run_end, input bit changed, input int abort_row);
        bus.cmd_step = 1'b0;
        for (int i = 1; i <= lat; i++) begin
            cyc("donewait", ST_DW, 0);
            bus.cmd_step      = rbit();
            bus.cmd_load      = rbit();
            bus.array_done    = (i == lat);
            bus.array_changed = changed;
        end
        for (int r = 0; r < ROWS; r++) begin
            cyc("store_row", ST_STORE, r);
            bus.array_done = 1'b0;
            if (r == abort_row) begin
                clear_cmds();
                reset = 1'b1;
                return;
            end
            bus.cmd_step = rbit();
            bus.cmd_load = rbit();
            bus.cmd_run  = rbit();
            if (r == ROWS - 1) begin
                bus.cmd_step = 1'b0;
                bus.cmd_load = 1'b0;
                bus.cmd_run  = run_end;
            end
        end
        exp_gen = (exp_gen + 1) % GEN_MOD;
    endtask

    // WAIT lasts DELAY+1 cycles, then one RUN cycle; returns the cycle number of the RUN pulse.
    task automatic wait_phase(output int t_run);
        for (int k = 0; k <= DELAY; k++) begin
            cyc("wait", ST_WAIT, 0);
            bus.cmd_run = 1'b1;
        end
        cyc("run_pulse", ST_RUN, 0);
        t_run = cyc_no;
    endtask

    task automatic step_gen(input int lat);
        bus.cmd_step = 1'b1;
        cyc("step_run", ST_RUN, 0);
        gen_body(lat, 1'b0, 1'b1, -1);
        cyc("step_idle", ST_IDLE, 0);
    endtask

    // chg_mode: 0 forces array_changed low, 1 high, 2 random.
    task automatic run_gens(input int n, input int lat, input int chg_mode);
        int prev;
        int plat;
        int t_run;
        int l;
        bit chg;
        prev = -1;
        plat = 0;
        bus.cmd_run = 1'b1;
        for (int g = 0; g < n; g++) begin
            wait_phase(t_run);
            if (prev >= 0) check("run_spacing", t_run - prev, 1 + plat + ROWS + DELAY + 1);
            l   = (lat > 0) ? lat : $urandom_range(1, 5);
            chg = (chg_mode == 2) ? rbit() : chg_mode[0];
            gen_body(l, (g < n - 1), chg, -1);
            prev = t_run;
            plat = l;
        end
        cyc("run_idle", ST_IDLE, 0);
    endtask

    task automatic drop_in_wait();
        int k;
        k = $urandom_range(0, DELAY);
        bus.cmd_run = 1'b1;
        for (int j = 0; j <= k; j++) begin
            cyc("drop_wait", ST_WAIT, 0);
            bus.cmd_run = (j != k);
        end
        cyc("drop_idle", ST_IDLE, 0);
    endtask

    task automatic step_in_wait(input int lat);
        int k;
        k = $urandom_range(0, DELAY);
        bus.cmd_run = 1'b1;
        for (int j = 0; j <= k; j++) begin
            cyc("stepw_wait", ST_WAIT, 0);
            bus.cmd_step = (j == k);
        end
        cyc("stepw_run", ST_RUN, 0);
        gen_body(lat, 1'b0, 1'b1, -1);
        cyc("stepw_idle", ST_IDLE, 0);
    endtask

    initial begin
        reset = 1'b1;
        clear_cmds();
        bus.array_changed = 1'b1;
        cyc("reset_state", ST_IDLE, 0);
        cyc("reset_state", ST_IDLE, 0);
        reset = 1'b0;
        cyc("post_reset", ST_IDLE, 0);

        do_load();
        step_gen(5);
        check("gen_after_step", 32'(bus.gen_count), 1);

        run_gens(3, 3, 1);
        drop_in_wait();
        run_gens(1, 4, 1);
        step_in_wait(2);

        // Reset on the second STORE row aborts the store and clears the generation count.
        bus.cmd_step = 1'b1;
        cyc("abort_run", ST_RUN, 0);
        gen_body(2, 1'b0, 1'b1, 1);
        exp_gen = 0;
        cyc("abort_reset", ST_IDLE, 0);
        reset = 1'b0;
        cyc("abort_idle", ST_IDLE, 0);

        for (int s = 0; s < GEN_MOD; s++) step_gen($urandom_range(1, 4));
        check("gen_wrap", 32'(bus.gen_count), 0);

`ifdef LIFE_AUTOSTOP_EN
        bus.cmd_run = 1'b1;
        begin
            int t_run;
            wait_phase(t_run);
        end
        gen_body(2, 1'b1, 1'b0, -1);
        for (int i = 0; i < 3; i++) begin
            cyc("autostop_idle", ST_IDLE, 0);
            bus.cmd_run = 1'b1;
        end
        bus.cmd_step = 1'b1;
        cyc("autostop_restart", ST_RUN, 0);
        gen_body(2, 1'b1, 1'b1, -1);
        cyc("autostop_resume", ST_WAIT, 0);
        bus.cmd_run = 1'b0;
        cyc("autostop_drop", ST_IDLE, 0);
`else
        run_gens(2, 2, 0);
`endif

        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 4))
                0: do_load();
                1: step_gen($urandom_range(1, 6));
                2: run_gens($urandom_range(1, 3), 0, AUTOSTOP ? 1 : 2);
                3: drop_in_wait();
                default: step_in_wait($urandom_range(1, 6));
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
